// File: rtl/button_debounce.sv
// Debounced push-button reader: two-flop synchronizer, counter-based debounce FSM,
// press/release/long-press pulses. Optional press counter under BTN_DEBOUNCE_PRESS_COUNT_EN.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES   = 500000,
  parameter int LONG_PRESS_CYCLES = 50000000,
  parameter bit ACTIVE_LOW        = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        btn_in,
  output logic        btn_level,
  output logic        press_pulse,
  output logic        release_pulse,
  output logic        long_press
`ifdef BTN_DEBOUNCE_PRESS_COUNT_EN
  ,
  output logic [15:0] press_count
`endif
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_W-1:0]   DB_ONE    = DB_W'(1);
  localparam logic [DB_W-1:0]   DB_ZERO   = {DB_W{1'b0}};
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_PRESS_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_ZERO = {HOLD_W{1'b0}};

  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_DB_PRESS   = 2'd1;
  localparam logic [1:0] ST_PRESSED    = 2'd2;
  localparam logic [1:0] ST_DB_RELEASE = 2'd3;

  logic              pressed_raw_s;
  logic              sync1_r;
  logic              sync2_r;
  logic [1:0]        state_r;
  logic [1:0]        state_s;
  logic [DB_W-1:0]   db_cnt_r;
  logic [DB_W-1:0]   db_cnt_s;
  logic [HOLD_W-1:0] hold_cnt_r;
  logic [HOLD_W-1:0] hold_cnt_s;
  logic              long_done_r;
  logic              long_done_s;
  logic              go_press_s;
  logic              go_release_s;
  logic              level_s;
  logic              long_s;

  // Normalize so that 1 always means "pressed" from here on.
  assign pressed_raw_s = btn_in ^ ACTIVE_LOW;

  // Next-state logic for the debounce FSM and its counters.
  always_comb begin
    state_s      = state_r;
    db_cnt_s     = db_cnt_r;
    hold_cnt_s   = hold_cnt_r;
    long_done_s  = long_done_r;
    go_press_s   = 1'b0;
    go_release_s = 1'b0;
    long_s       = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (sync2_r) begin
          if (DEBOUNCE_CYCLES == 1) begin
            go_press_s = 1'b1;
          end else begin
            state_s  = ST_DB_PRESS;
            db_cnt_s = DB_ONE;
          end
        end else begin
          db_cnt_s = DB_ZERO;
        end
      end
      ST_DB_PRESS: begin
        if (!sync2_r) begin
          state_s  = ST_IDLE;
          db_cnt_s = DB_ZERO;
        end else if (db_cnt_r == DB_LAST) begin
          go_press_s = 1'b1;
        end else begin
          db_cnt_s = db_cnt_r + DB_ONE;
        end
      end
      ST_PRESSED: begin
        if (!sync2_r) begin
          if (DEBOUNCE_CYCLES == 1) begin
            go_release_s = 1'b1;
          end else begin
            state_s  = ST_DB_RELEASE;
            db_cnt_s = DB_ONE;
          end
        end else begin
          // Fire once when the saturated hold count is seen; long_done blocks re-fire.
          if (hold_cnt_r < HOLD_MAX) begin
            hold_cnt_s = hold_cnt_r + HOLD_ONE;
          end else begin
            hold_cnt_s = hold_cnt_r;
          end
          if ((hold_cnt_r == HOLD_MAX) && !long_done_r) begin
            long_s      = 1'b1;
            long_done_s = 1'b1;
          end else begin
            long_s = 1'b0;
          end
        end
      end
      ST_DB_RELEASE: begin
        if (sync2_r) begin
          state_s  = ST_PRESSED;
          db_cnt_s = DB_ZERO;
        end else if (db_cnt_r == DB_LAST) begin
          go_release_s = 1'b1;
        end else begin
          db_cnt_s = db_cnt_r + DB_ONE;
        end
      end
      default: begin
        state_s     = ST_IDLE;
        db_cnt_s    = DB_ZERO;
        hold_cnt_s  = HOLD_ZERO;
        long_done_s = 1'b0;
      end
    endcase

    if (go_press_s) begin
      state_s     = ST_PRESSED;
      db_cnt_s    = DB_ZERO;
      hold_cnt_s  = HOLD_ONE;
      long_done_s = 1'b0;
    end else if (go_release_s) begin
      state_s    = ST_IDLE;
      db_cnt_s   = DB_ZERO;
      hold_cnt_s = HOLD_ZERO;
    end else begin
      state_s = state_s;
    end

    if (go_press_s) begin
      level_s = 1'b1;
    end else if (go_release_s) begin
      level_s = 1'b0;
    end else begin
      level_s = btn_level;
    end
  end

  // State, synchronizer and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_r       <= 1'b0;
      sync2_r       <= 1'b0;
      state_r       <= ST_IDLE;
      db_cnt_r      <= DB_ZERO;
      hold_cnt_r    <= HOLD_ZERO;
      long_done_r   <= 1'b0;
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_press    <= 1'b0;
    end else begin
      sync1_r       <= pressed_raw_s;
      sync2_r       <= sync1_r;
      state_r       <= state_s;
      db_cnt_r      <= db_cnt_s;
      hold_cnt_r    <= hold_cnt_s;
      long_done_r   <= long_done_s;
      btn_level     <= level_s;
      press_pulse   <= go_press_s;
      release_pulse <= go_release_s;
      long_press    <= long_s;
    end
  end

`ifdef BTN_DEBOUNCE_PRESS_COUNT_EN
  // Accepted-press counter, wraps naturally at 16 bits.
  always_ff @(posedge clock) begin
    if (reset) begin
      press_count <= 16'h0000;
    end else if (go_press_s) begin
      press_count <= press_count + 16'h0001;
    end else begin
      press_count <= press_count;
    end
  end
`endif

endmodule

// File: tb/tb_button_debounce.sv
// Randomized scoreboard bench for button_debounce: a run-length reference model
// feeds expectation queues, a negedge monitor pops and compares.
module tb_button_debounce;

  localparam int D  = 4;
  localparam int L  = 10;
  localparam bit AL = 1'b1;

  logic clock = 1'b0;
  logic reset;
  logic btn_in;
  logic btn_level;
  logic press_pulse;
  logic release_pulse;
  logic long_press;
`ifdef BTN_DEBOUNCE_PRESS_COUNT_EN
  logic [15:0] press_count;
`endif

  always #5 clock = ~clock;

  button_debounce #(
    .DEBOUNCE_CYCLES  (D),
    .LONG_PRESS_CYCLES(L),
    .ACTIVE_LOW       (AL)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .btn_in       (btn_in),
    .btn_level    (btn_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .long_press   (long_press)
`ifdef BTN_DEBOUNCE_PRESS_COUNT_EN
    ,
    .press_count  (press_count)
`endif
  );

  typedef struct {
    int cyc;
    bit level;
    int cnt;
  } lev_t;

  typedef struct {
    int cyc;
    bit press;
    bit rel;
    bit lp;
  } ev_t;

  lev_t levq[$];
  ev_t  evq[$];

  int total = 0;
  int bad   = 0;

  // Reference model state (higher-level view: a run of disagreeing samples)
  int cyc = 0;
  bit m_s1, m_s2, m_level, m_fired;
  int m_run, m_hc, m_cnt, m_presses;

  // Directed latency arming, written by stimulus only
  int press_cap = 0, rel_cap = 0, press_arm = 0, rel_arm = 0;
  bit fin_req = 1'b0;

  // Monitor-owned state
  int press_done = 0, long_done = 0, rel_done = 0, last_press_cyc = 0, seen_press = 0;
  bit fin_done = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v, input int at);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, at, act, exp_v);
    end
  endtask

  task automatic step(input bit pin, input bit rst);
    bit smp, pn, pr, rl, lp;
    lev_t lv;
    ev_t  ev;
    btn_in = pin;
    reset  = rst;
    @(posedge clock);
    cyc++;
    pn = AL ? ~pin : pin;
    pr = 1'b0; rl = 1'b0; lp = 1'b0;
    if (rst) begin
      m_s1 = 1'b0; m_s2 = 1'b0; m_level = 1'b0; m_fired = 1'b0;
      m_run = 0; m_hc = 0; m_cnt = 0;
    end else begin
      smp  = m_s2;
      m_s2 = m_s1;
      m_s1 = pn;
      if (smp != m_level) begin
        m_run++;
        if (m_run == D) begin
          m_run   = 0;
          m_level = smp;
          if (smp) begin
            pr = 1'b1; m_hc = 0; m_fired = 1'b0;
            m_cnt = (m_cnt + 1) & 32'hFFFF;
            m_presses++;
          end else begin
            rl = 1'b1;
          end
        end
      end else if (m_run != 0) begin
        m_run = 0;
      end else if (m_level) begin
        if (m_hc < L) m_hc++;
        if (m_hc == L && !m_fired) begin
          lp = 1'b1;
          m_fired = 1'b1;
        end
      end
    end
    lv.cyc = cyc; lv.level = m_level; lv.cnt = m_cnt;
    levq.push_back(lv);
    if (pr || rl || lp) begin
      ev.cyc = cyc; ev.press = pr; ev.rel = rl; ev.lp = lp;
      evq.push_back(ev);
    end
    #1;
  endtask

  task automatic hold(input bit pin, input int n, input bit rst);
    for (int i = 0; i < n; i++) step(pin, rst);
  endtask

  // Monitor: one expectation per cycle, event queue checked whenever a pulse is due or seen.
  always @(negedge clock) begin
    lev_t lv;
    ev_t  ev;
    if (levq.size() > 0) begin
      lv = levq.pop_front();
      chk("btn_level", {31'd0, btn_level}, {31'd0, lv.level}, lv.cyc);
`ifdef BTN_DEBOUNCE_PRESS_COUNT_EN
      chk("press_count", {16'd0, press_count}, lv.cnt, lv.cyc);
`endif
      if (evq.size() > 0 && evq[0].cyc == lv.cyc) begin
        ev = evq.pop_front();
        chk("press_pulse", {31'd0, press_pulse}, {31'd0, ev.press}, lv.cyc);
        chk("release_pulse", {31'd0, release_pulse}, {31'd0, ev.rel}, lv.cyc);
        chk("long_press", {31'd0, long_press}, {31'd0, ev.lp}, lv.cyc);
      end else begin
        chk("no_pulse", {29'd0, press_pulse, release_pulse, long_press}, 32'd0, lv.cyc);
      end
      if (press_pulse) begin
        seen_press++;
        last_press_cyc = lv.cyc;
        if (press_done != press_arm) begin
          // capture edge counted as the first of D+2 edges
          chk("press_latency", lv.cyc - press_cap, D + 1, lv.cyc);
          press_done = press_arm;
        end
      end
      if (long_press && long_done != press_arm) begin
        chk("long_latency", lv.cyc - last_press_cyc, L, lv.cyc);
        long_done = press_arm;
      end
      if (release_pulse && rel_done != rel_arm) begin
        chk("release_latency", lv.cyc - rel_cap, D + 1, lv.cyc);
        rel_done = rel_arm;
      end
    end
    if (fin_req && !fin_done) begin
      chk("levq_drained", levq.size(), 32'd0, cyc);
      chk("evq_drained", evq.size(), 32'd0, cyc);
      chk("press_total", seen_press, m_presses, cyc);
      fin_done = 1'b1;
    end
  end

  initial begin
    int lvl, len;
    m_s1 = 1'b0; m_s2 = 1'b0; m_level = 1'b0; m_fired = 1'b0;
    m_run = 0; m_hc = 0; m_cnt = 0; m_presses = 0;

    hold(1'b1, 3, 1'b1);
    hold(1'b1, 5, 1'b0);

    // Clean press held long enough for long_press, then clean release
    step(1'b0, 1'b0);
    press_cap = cyc; press_arm++;
    hold(1'b0, 19, 1'b0);
    step(1'b1, 1'b0);
    rel_cap = cyc; rel_arm++;
    hold(1'b1, 11, 1'b0);

    // 3-cycle burst, one-cycle gap, then steady press
    hold(1'b0, 3, 1'b0);
    step(1'b1, 1'b0);
    hold(1'b0, 20, 1'b0);
    hold(1'b1, 10, 1'b0);

    // Short press: released well before the long-press threshold
    hold(1'b0, 6 + 5, 1'b0);
    hold(1'b1, 10, 1'b0);

    // Release bounce inside a 30-cycle hold
    hold(1'b0, 12, 1'b0);
    hold(1'b1, 2, 1'b0);
    hold(1'b0, 18, 1'b0);
    hold(1'b1, 10, 1'b0);

    // Reset while pressed, button held through it
    hold(1'b0, 15, 1'b0);
    step(1'b0, 1'b1);
    hold(1'b0, 15, 1'b0);
    hold(1'b1, 10, 1'b0);

    // Randomized bouncing runs with sparse resets
    for (int b = 0; b < 200; b++) begin
      lvl = $urandom_range(0, 1);
      len = ($urandom_range(0, 9) == 0) ? 40 : $urandom_range(1, 12);
      for (int i = 0; i < len; i++) step(lvl[0], $urandom_range(0, 299) == 0);
    end

    hold(1'b1, 20, 1'b0);
    fin_req = 1'b1;
    for (int i = 0; i < 10 && !fin_done; i++) @(negedge clock);
    if (!fin_done) begin
      total++;
      bad++;
      $display("FAIL final_checks: got 0 expected 1");
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
